// File: rtl/mccoy_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mccoy_pkg : opcode/state encodings and operand-extension helpers  |
// | Revision  : 1.0                                                   |
// +------------------------------------------------------------------+
package mccoy_pkg;

   typedef enum logic [2:0] {
      OP_LDR = 3'd0,
      OP_STR = 3'd1,
      OP_LDI = 3'd2,
      OP_ADD = 3'd3,
      OP_NOT = 3'd4,
      OP_BEZ = 3'd5,
      OP_JA  = 3'd6,
      OP_HLT = 3'd7
   } opcode_e;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   // Bit i of a fw-bit field sign-extended to any width.
   function automatic logic sx_bit(input logic [31:0] f, input int unsigned fw,
                                   input int unsigned i);
      return (i < fw) ? f[i] : f[fw-1];
   endfunction

   // Bit i of a w-bit value zero-extended (or truncated) to any width.
   function automatic logic zx_bit(input logic [31:0] v, input int unsigned w,
                                   input int unsigned i);
      return (i < w) ? v[i] : 1'b0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mccoy_regfile.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mccoy_regfile : async-read / sync-write register file, sync clear |
// | Revision      : 1.0                                               |
// +------------------------------------------------------------------+
module mccoy_regfile #(
   parameter  int DATA_W = 8,
   parameter  int NREGS  = 8,
   localparam int AW     = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [NREGS];
   logic [DATA_W-1:0] mem_d [NREGS];

   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/mccoy_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mccoy_core : stallable accumulator core with RUN/HALT control     |
// | Revision   : 1.0                                                  |
// +------------------------------------------------------------------+
module mccoy_core
   import mccoy_pkg::*;
#(
   parameter  int DATA_W  = 8,
   parameter  int PC_W    = 8,
   parameter  int NREGS   = 8,
   localparam int REG_AW  = $clog2(NREGS),
   localparam int INSTR_W = 3 + REG_AW
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] instr,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic               resume,
   output logic [PC_W-1:0]    pc,
   output logic [DATA_W-1:0]  acc,
   output logic               halted
);

   state_e              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [DATA_W-1:0]   acc_q, acc_d;

   opcode_e             op;
   logic [REG_AW-1:0]   fld;
   logic                accept;
   logic                rf_we;
   logic [DATA_W-1:0]   rf_rdata;
   logic [DATA_W-1:0]   imm_acc;
   logic [PC_W-1:0]     imm_pc;
   logic [PC_W-1:0]     ja_pc;
   logic [PC_W-1:0]     pc_inc;

   assign op     = opcode_e'(instr[2:0]);
   assign fld    = instr[INSTR_W-1:3];
   assign accept = instr_valid && (state_q == ST_RUN);
   assign pc_inc = pc_q + PC_W'(1);

   mccoy_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS)
   ) u_rf (
      .clk   (clk),
      .reset (reset),
      .we    (rf_we),
      .waddr (fld),
      .wdata (acc_q),
      .raddr (fld),
      .rdata (rf_rdata)
   );

   // Operand widening: immediates sign-extend, jump targets zero-extend.
   always_comb begin
      imm_acc = '0;
      imm_pc  = '0;
      ja_pc   = '0;
      for (int i = 0; i < DATA_W; i++) imm_acc[i] = sx_bit(32'(fld), REG_AW, i);
      for (int i = 0; i < PC_W; i++) begin
         imm_pc[i] = sx_bit(32'(fld), REG_AW, i);
         ja_pc[i]  = zx_bit(32'(rf_rdata), DATA_W, i);
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      acc_d   = acc_q;
      rf_we   = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (accept) begin
               pc_d = pc_inc;
               case (op)
                  OP_LDR: acc_d = rf_rdata;
                  OP_STR: rf_we = 1'b1;
                  OP_LDI: acc_d = imm_acc;
                  OP_ADD: acc_d = acc_q + rf_rdata;
                  OP_NOT: acc_d = ~acc_q;
                  OP_BEZ: if (acc_q == '0) pc_d = pc_q + imm_pc;
                  OP_JA:  pc_d = ja_pc;
                  OP_HLT: state_d = ST_HALT;
                  default: ;
               endcase
            end
         end
         ST_HALT: if (resume) state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         pc_q    <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         acc_q   <= acc_d;
      end
   end

   assign instr_ready = (state_q == ST_RUN);
   assign halted      = (state_q == ST_HALT);
   assign pc          = pc_q;
   assign acc         = acc_q;

endmodule
`default_nettype wire

// File: doc/mccoy_core.md
# mccoy_core

Parametrised second-generation McCoy accumulator core. The data width, PC width and register-file depth are configurable. Instructions arrive over a valid/ready stream instead of being sampled raw every cycle, so the core can stall. A HALT state is left only by `resume` or `reset`. The core sits between the external instruction source, which fetches at `pc`, and the chip-level I/O, which observes `pc`/`acc`.

## Interface
- `DATA_W`, 8: accumulator and register width (≥4).
- `PC_W`, 8: program counter width (≥4).
- `NREGS`, 8: register-file depth, a power of two ≥2. `REG_AW = clog2(NREGS)`. Instruction width `INSTR_W = 3 + REG_AW`.
- `clk`, in, 1: the one clock.
- `reset`, in, 1: synchronous, active-high.
- `instr`, in, INSTR_W: `[2:0]` opcode, `[INSTR_W-1:3]` operand field `f` (register address or signed immediate).
- `instr_valid`, in, 1: `instr` is valid this cycle.
- `instr_ready`, out, 1: the core accepts an instruction this cycle.
- `resume`, in, 1: leave HALT.
- `pc`, out, PC_W: address of the next instruction wanted.
- `acc`, out, DATA_W: accumulator.
- `halted`, out, 1: core is in HALT.

## Operation
- FSM states: RUN and HALT. `instr_ready = (state==RUN)`. `halted = (state==HALT)`.
- An instruction is accepted when `instr_valid && instr_ready`. Its effects land at that clock edge.
- When nothing is accepted, `pc`, `acc` and the register file hold their values.
- `sx(f)` is `f` sign-extended to the destination width.
- Opcodes. Unless stated otherwise, `pc <= pc+1`.
  - 0 LDR: `acc <= r[f]`.
  - 1 STR: `r[f] <= acc`.
  - 2 LDI: `acc <= sx(f)`.
  - 3 ADD: `acc <= acc + r[f]`, mod 2^DATA_W, no flags.
  - 4 NOT: `acc <= ~acc`.
  - 5 BEZ: if `acc==0` then `pc <= pc + sx(f)` mod 2^PC_W, else `pc <= pc+1`.
  - 6 JA: `pc <= r[f]`, truncated or zero-extended to PC_W.
  - 7 HLT: `pc <= pc+1`, state goes to HALT.
- In HALT:
  - `resume` high moves the state to RUN at the next edge. `instr_ready` is 0 during the resume cycle, so nothing is accepted in it.
  - `resume` is ignored in RUN.
- All PC arithmetic wraps modulo 2^PC_W.
- An STR followed by an LDR of the same register returns the stored value; no bypass is needed.

## Timing
- Reset values: `pc=0`, `acc=0`, all `r[i]=0`, state RUN, `instr_ready=1`, `halted=0`.
- `reset` overrides every other input in the same cycle, including an accepted instruction and `resume`.
- Reset asserted mid-stream discards the instruction presented that cycle.
- Latency: an instruction accepted at edge N has its results visible on `acc`/`pc` after edge N.
- Throughput: one instruction per cycle while `instr_valid` is high.
- All outputs are registered or decoded from state only. There is no combinational path from `instr` to any output.
- Back-to-back dependent instructions (for example LDI then ADD) need no stall.
- HLT accepted at edge N: `halted=1` and `instr_ready=0` from N.
- `resume` sampled at edge M: `instr_ready=1` from M, and the first new accept is at M+1.

## Structure
- Package `mccoy_pkg` holds:
  - the opcode enum (`OP_LDR`…`OP_HLT`);
  - the state enum (`ST_RUN`, `ST_HALT`);
  - the sign-extension helper function.
- Sub-module `mccoy_regfile #(DATA_W, NREGS)`: one asynchronous read port, one synchronous write port, synchronous reset clears all entries.
- Top level `mccoy_core` contains the decode, the FSM, `pc`, `acc`, and the next-PC/ALU logic.

## Test plan
1. Reset, then stream LDI 3, STR r2, LDI -1, ADD r2 (defaults) -> `acc=0x02`, `pc=4`, `r2=0x03`.
2. LDI 0, then NOT -> `acc=0xFF`. Then BEZ f=-2 -> `pc` advances by 1 (not taken). LDI 0, then BEZ f=-2 at `pc=5` -> `pc=3`.
3. Hold `instr_valid=0` for 3 cycles mid-program -> `pc`, `acc` and registers unchanged; `instr_ready` stays 1.
4. HLT at `pc=7` -> `pc=8`, `halted=1`, `instr_ready=0`. A valid LDI presented for 4 cycles is ignored. Pulse `resume` -> next cycle `instr_ready=1` and the LDI is accepted.
5. Wrap-around:
   - store 0xFF to r1, JA r1, then NOT -> `pc=0x00`;
   - BEZ f=+1 at `pc=0xFF` with `acc=0` -> `pc=0x00`.
6. Configuration DATA_W=16, PC_W=10, NREGS=16: LDI -1, STR r15, LDI 1, ADD r15 -> `acc=0x0000`. Then assert `reset` in the same cycle as a valid LDI 5 -> all outputs return to their reset values and `acc=0`.
